// File: rtl/foc_pkg.sv
// Shared types and helpers for the FOC setpoint/limiter blocks.
package foc_pkg;

  typedef enum logic [1:0] {
    SP_ZERO     = 2'd0,
    SP_SQUARE   = 2'd1,
    SP_TRIANGLE = 2'd2,
    SP_CONST    = 2'd3
  } setpt_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } tri_dir_t;

  // Symmetric saturation to +/-(2^(w-1)-1); the most negative code is never produced.
  function automatic logic signed [31:0] sat_w(input logic signed [31:0] x, input int w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (x > lim)       return lim;
    else if (x < -lim) return -lim;
    else               return x;
  endfunction

endpackage

// File: rtl/slew_limiter.sv
// Rate limiter: moves cur toward target by at most step (step==0 means jump).
// Purely combinational; the caller owns the state register.
module slew_limiter
  import foc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] i_cur,
  input  logic signed [WIDTH-1:0] i_target,
  input  logic        [WIDTH-2:0] i_step,
  output logic signed [WIDTH-1:0] o_next
);

  localparam int XW = WIDTH + 2;

  logic signed [XW-1:0] cur_x, tgt_x, step_x, diff_x, mag_x, move_x;

  // Widen, compare |target-cur| with the step, and saturate the result.
  always_comb begin
    cur_x  = XW'(i_cur);
    tgt_x  = XW'(i_target);
    step_x = {3'b000, i_step};
    diff_x = tgt_x - cur_x;
    mag_x  = (diff_x < 0) ? -diff_x : diff_x;
    if ((i_step == '0) || (mag_x <= step_x)) begin
      move_x = tgt_x;
    end else if (diff_x > 0) begin
      move_x = cur_x + step_x;
    end else begin
      move_x = cur_x - step_x;
    end
    o_next = WIDTH'(sat_w(32'(move_x), WIDTH));
  end

endmodule

// File: rtl/iq_setpoint_gen.sv
// Current-setpoint generator: ZERO / SQUARE / TRIANGLE / CONST waveforms,
// updated once per control tick, with amplitude clamp and slew limiting.
module iq_setpoint_gen
  import foc_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter int               CNT_W   = 16,
  parameter logic [WIDTH-1:0] MAX_AMP = 16'd4000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_tick,
  input  logic [1:0]              i_mode,
  input  logic [WIDTH-2:0]        i_amp,
  input  logic [CNT_W-1:0]        i_half_period,
  input  logic [WIDTH-2:0]        i_slew,
  output logic signed [WIDTH-1:0] o_aim,
  output logic                    o_en,
  output logic                    o_flip
);

  localparam int XW = WIDTH + 2;

  setpt_mode_t             mode_q, mode_d, mode_in;
  tri_dir_t                dir_q, dir_d, dir_e;
  logic                    phase_q, phase_d, phase_e;
  logic [CNT_W-1:0]        cnt_q, cnt_d, hp_e;
  logic signed [WIDTH-1:0] aim_q, aim_d;
  logic                    en_q, en_d, flip_q, flip_d;
  logic                    mode_chg;
  logic [WIDTH-2:0]        amp_e;
  logic signed [WIDTH-1:0] amp_w, target, slew_next, tri_next;
  logic signed [XW-1:0]    amp_x, aim_x, step_x, cand_x, clamp_x;
  logic                    outside, tri_rev;

  // Effective operands; a mode change makes phase/dir look freshly reset this cycle.
  always_comb begin
    mode_in  = setpt_mode_t'(i_mode);
    mode_chg = (mode_in != mode_q);
    amp_e    = ({1'b0, i_amp} > MAX_AMP) ? MAX_AMP[WIDTH-2:0] : i_amp;
    amp_w    = signed'({1'b0, amp_e});
    amp_x    = {3'b000, amp_e};
    hp_e     = (i_half_period == '0) ? CNT_W'(1) : i_half_period;
    phase_e  = mode_chg ? 1'b0 : phase_q;
    dir_e    = mode_chg ? DIR_UP : dir_q;
  end

  // Target level for the slew-limited modes.
  always_comb begin
    case (mode_in)
      SP_CONST:  target = amp_w;
      SP_SQUARE: target = phase_e ? amp_w : -amp_w;
      default:   target = '0;
    endcase
  end

  slew_limiter #(.WIDTH(WIDTH)) u_slew (
    .i_cur    (aim_q),
    .i_target (target),
    .i_step   (i_slew),
    .o_next   (slew_next)
  );

  // Triangle step with clamp; reversal only when starting inside the limits.
  always_comb begin
    aim_x   = XW'(aim_q);
    step_x  = (i_slew == '0) ? XW'(1) : {3'b000, i_slew};
    cand_x  = (dir_e == DIR_UP) ? (aim_x + step_x) : (aim_x - step_x);
    outside = (aim_x > amp_x) || (aim_x < -amp_x);
    tri_rev = 1'b0;
    if (cand_x >= amp_x) begin
      clamp_x = amp_x;
      tri_rev = !outside && (dir_e == DIR_UP);
    end else if (cand_x <= -amp_x) begin
      clamp_x = -amp_x;
      tri_rev = !outside && (dir_e == DIR_DOWN);
    end else begin
      clamp_x = cand_x;
    end
    tri_next = WIDTH'(sat_w(32'(clamp_x), WIDTH));
  end

  // Next-state: mode change first, then tick processing against the new mode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    aim_d   = aim_q;
    en_d    = 1'b0;
    flip_d  = 1'b0;
    if (mode_chg) begin
      mode_d  = mode_in;
      cnt_d   = '0;
      phase_d = 1'b0;
      dir_d   = DIR_UP;
    end
    if (i_tick) begin
      en_d = 1'b1;
      case (mode_in)
        SP_TRIANGLE: begin
          aim_d = tri_next;
          if (!mode_chg && tri_rev) begin
            dir_d  = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
            flip_d = 1'b1;
          end
        end
        SP_SQUARE: begin
          aim_d = slew_next;
          if (!mode_chg) begin
            if (cnt_q >= hp_e - CNT_W'(1)) begin
              cnt_d   = '0;
              phase_d = ~phase_q;
              flip_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: aim_d = slew_next;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      mode_q  <= SP_ZERO;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      dir_q   <= DIR_UP;
      aim_q   <= '0;
      en_q    <= 1'b0;
      flip_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      aim_q   <= aim_d;
      en_q    <= en_d;
      flip_q  <= flip_d;
    end
  end

  assign o_aim  = aim_q;
  assign o_en   = en_q;
  assign o_flip = flip_q;

endmodule

// File: tb/tb_iq_setpoint_gen.sv
// Scoreboard bench for iq_setpoint_gen: stimulus queues expected (aim, flip)
// per tick; a negedge monitor pops and compares whenever o_en is high.
module tb_iq_setpoint_gen;
  import foc_pkg::*;

  localparam int GAP = 7;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_tick = 1'b0;
  logic [1:0]         i_mode = SP_ZERO;
  logic [14:0]        i_amp = '0;
  logic [15:0]        i_half_period = '0;
  logic [14:0]        i_slew = '0;
  logic signed [15:0] o_aim;
  logic               o_en;
  logic               o_flip;

  typedef struct {
    int aim;
    bit flip;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  iq_setpoint_gen dut (
    .clk           (clk),
    .rst           (rst),
    .i_tick        (i_tick),
    .i_mode        (i_mode),
    .i_amp         (i_amp),
    .i_half_period (i_half_period),
    .i_slew        (i_slew),
    .o_aim         (o_aim),
    .o_en          (o_en),
    .o_flip        (o_flip)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: pop one expectation per o_en pulse; o_flip must never appear alone.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_en", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("aim", int'(o_aim), e.aim);
          check("flip", int'(o_flip), int'(e.flip));
        end
      end else begin
        check("flip_without_en", int'(o_flip), 0);
      end
    end
  end

  // One tick pulse, then idle so ticks are 8 clocks apart.
  task automatic do_tick(input int exp_aim, input bit exp_flip);
    exp_t e;
    e.aim  = exp_aim;
    e.flip = exp_flip;
    exp_q.push_back(e);
    i_tick = 1'b1;
    @(posedge clk); #1;
    i_tick = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input setpt_mode_t m);
    i_mode = m;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_aim", int'(o_aim), 0);
    check("rst_en", int'(o_en), 0);
    check("rst_flip", int'(o_flip), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // SQUARE amp=200 hp=4 slew=0: -200 x4, +200 x4, -200 x4, flip every 4th tick
    i_amp = 15'd200; i_half_period = 16'd4; i_slew = '0;
    set_mode(SP_SQUARE);
    for (int i = 0; i < 12; i++) begin
      do_tick((((i / 4) % 2) == 0) ? -200 : 200, (i % 4) == 3);
    end

    // Phase now +200, o_aim=-200; slew=50 with a long half-period
    i_slew = 15'd50; i_half_period = 16'd16;
    for (int i = 1; i <= 8; i++) begin
      do_tick(-200 + 50 * i, 1'b0);
    end

    // Half-period shrunk below cnt (8): next tick wraps immediately
    i_half_period = 16'd4;
    do_tick(200, 1'b1);

    // SQUARE -> ZERO together with a tick: straight to 0, no flip
    i_slew = '0;
    i_mode = SP_ZERO;
    do_tick(0, 1'b0);

    // TRIANGLE amp=100 slew=30 from 0
    i_amp = 15'd100; i_slew = 15'd30;
    set_mode(SP_TRIANGLE);
    do_tick(30, 1'b0);
    do_tick(60, 1'b0);
    do_tick(90, 1'b0);
    do_tick(100, 1'b1);
    do_tick(70, 1'b0);
    do_tick(40, 1'b0);
    do_tick(10, 1'b0);
    do_tick(-20, 1'b0);
    do_tick(-50, 1'b0);
    do_tick(-80, 1'b0);
    do_tick(-100, 1'b1);
    do_tick(-70, 1'b0);

    // Amplitude shrinks under o_aim=-70: clamp without reversal, then continue
    i_amp = 15'd20;
    do_tick(-20, 1'b0);
    do_tick(10, 1'b0);
    do_tick(20, 1'b1);

    // CONST with oversize amplitude, mode change and tick together
    i_amp = 15'h7FFF; i_slew = '0;
    i_mode = SP_CONST;
    do_tick(4000, 1'b0);
    do_tick(4000, 1'b0);

    // SQUARE with hp=0 behaves as hp=1: toggles every tick
    i_amp = 15'd200; i_half_period = '0;
    set_mode(SP_SQUARE);
    do_tick(-200, 1'b1);
    do_tick(200, 1'b1);
    do_tick(-200, 1'b1);
    do_tick(200, 1'b1);
    do_tick(-200, 1'b1);

    // Slew from -200 toward +200, then reset mid-cycle while o_en is high
    i_half_period = 16'd16; i_slew = 15'd50;
    begin
      exp_t e;
      e.aim  = -150;
      e.flip = 1'b0;
      exp_q.push_back(e);
    end
    i_tick = 1'b1;
    @(posedge clk); #1;
    i_tick = 1'b0;
    @(negedge clk); #1;
    check("pre_rst_aim", int'(o_aim), -150);
    check("pre_rst_en", int'(o_en), 1);
    rst = 1'b1;
    #1;
    check("async_rst_aim", int'(o_aim), 0);
    check("async_rst_en", int'(o_en), 0);
    check("async_rst_flip", int'(o_flip), 0);
    // Tick during reset is ignored
    i_tick = 1'b1;
    @(posedge clk); #1;
    i_tick = 1'b0;
    i_mode = SP_ZERO;
    check("rst_hold_aim", int'(o_aim), 0);
    check("rst_hold_en", int'(o_en), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_tick(0, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
